// File: rtl/dn_port_arbiter.sv
// dn_port_arbiter: shares the core's dn_* port between the hiscore
// engine, the HPS NVRAM dump and ROM download (ROM always wins).
module dn_port_arbiter #(
  parameter int PAUSEPAD = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        rom_active,
  input  logic        rom_wr,
  input  logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        hs_req,
  input  logic        hs_wr,
  input  logic [7:0]  hs_addr,
  input  logic [7:0]  hs_wdata,
  output logic        hs_gnt,
  input  logic        io_req,
  input  logic        io_wr,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_wdata,
  output logic        io_gnt,
  input  logic        cpu_paused,
  output logic        pause_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        mem_nvram,
  output logic        timeout_err
);

  localparam int SW = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(PAUSEPAD - 1);
  localparam logic [9:0]    TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_WAIT,
    SETTLE,
    GRANT,
    RELEASE,
    ROM
  } state_t;

  state_t        state, state_n;
  logic          owner, owner_n;
  logic          last_io, last_n;
  logic [9:0]    tmo_cnt, tmo_n;
  logic [SW-1:0] set_cnt, set_n;
  logic          err_n;

  logic          own_req;
  logic          own_wr;
  logic [7:0]    own_addr;
  logic [7:0]    own_wdata;
  logic          in_grant;

  // owner = 1 selects the io port, 0 the hiscore port
  assign own_req   = owner ? io_req   : hs_req;
  assign own_wr    = owner ? io_wr    : hs_wr;
  assign own_addr  = owner ? io_addr  : hs_addr;
  assign own_wdata = owner ? io_wdata : hs_wdata;

  assign in_grant  = (state == GRANT);
  assign hs_gnt    = in_grant & ~owner;
  assign io_gnt    = in_grant & owner;
  assign mem_nvram = in_grant;
  assign pause_req = (state == PAUSE_WAIT) | (state == SETTLE) | in_grant;

  // state, ownership and counter registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_io     <= 1'b1;
      tmo_cnt     <= '0;
      set_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last_io     <= last_n;
      tmo_cnt     <= tmo_n;
      set_cnt     <= set_n;
      timeout_err <= err_n;
    end
  end

  // next-state: ROM preempts everything, otherwise pause handshake
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_io;
    tmo_n   = tmo_cnt;
    set_n   = set_cnt;
    err_n   = timeout_err;
    if (rom_active) begin
      state_n = ROM;
    end else begin
      case (state)
        IDLE: begin
          if (hs_req || io_req) begin
            owner_n = io_req & ~(hs_req & last_io);
            tmo_n   = '0;
            state_n = PAUSE_WAIT;
          end
        end
        PAUSE_WAIT: begin
          if (!own_req) begin
            state_n = RELEASE;
          end else if (cpu_paused) begin
            set_n   = '0;
            state_n = SETTLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_n   = 1'b1;
            state_n = RELEASE;
          end else begin
            tmo_n = tmo_cnt + 10'd1;
          end
        end
        SETTLE: begin
          if (!own_req) begin
            state_n = RELEASE;
          end else if (!cpu_paused) begin
            state_n = PAUSE_WAIT;
          end else if (set_cnt == SET_LAST) begin
            state_n = GRANT;
          end else begin
            set_n = set_cnt + SW'(1);
          end
        end
        GRANT: begin
          if (!own_req) state_n = RELEASE;
        end
        RELEASE: begin
          last_n  = owner;
          state_n = IDLE;
        end
        ROM: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    if (state_n == GRANT && state != GRANT) err_n = 1'b0;
  end

  // registered memory port; only ROM or a settled owner can write
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
    end else if (state_n == ROM) begin
      mem_addr  <= rom_addr;
      mem_wdata <= rom_data;
      mem_wr    <= rom_wr;
    end else if (in_grant && state_n == GRANT) begin
      mem_addr  <= {8'h00, own_addr};
      mem_wdata <= own_wdata;
      mem_wr    <= own_wr;
    end else begin
      mem_wr    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dn_port_arbiter.sv
// tb_dn_port_arbiter: directed scenarios plus randomized sessions
// scored against a round-robin / fixed-latency transaction model.
module tb_dn_port_arbiter;

  localparam int PAUSEPAD = 2;
  localparam int TIMEOUT  = 1023;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        rom_active = 1'b0;
  logic        rom_wr = 1'b0;
  logic [15:0] rom_addr = '0;
  logic [7:0]  rom_data = '0;
  logic        hs_req = 1'b0;
  logic        hs_wr = 1'b0;
  logic [7:0]  hs_addr = '0;
  logic [7:0]  hs_wdata = '0;
  logic        hs_gnt;
  logic        io_req = 1'b0;
  logic        io_wr = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [7:0]  io_wdata = '0;
  logic        io_gnt;
  logic        cpu_paused = 1'b0;
  logic        pause_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_nvram;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  bit last_io = 1'b1;

  dn_port_arbiter #(
    .PAUSEPAD(PAUSEPAD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .rom_active (rom_active),
    .rom_wr     (rom_wr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .hs_req     (hs_req),
    .hs_wr      (hs_wr),
    .hs_addr    (hs_addr),
    .hs_wdata   (hs_wdata),
    .hs_gnt     (hs_gnt),
    .io_req     (io_req),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_gnt     (io_gnt),
    .cpu_paused (cpu_paused),
    .pause_req  (pause_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_nvram  (mem_nvram),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // round robin: io wins a tie only if hs was served last
  function automatic bit pick(input bit h, input bit i);
    return i && (!h || !last_io);
  endfunction

  task automatic wait_pause();
    int n = 0;
    while (pause_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("pause_req_up", 32'(pause_req), 32'(1));
  endtask

  // pause ack seen on the next edge, then PAUSEPAD settle cycles
  task automatic handshake(input bit exp_io, input int dly);
    wait_pause();
    repeat (dly) tick();
    cpu_paused = 1'b1;
    for (int k = 0; k < PAUSEPAD + 1; k++) begin
      tick();
      if (k < PAUSEPAD)
        chk("gnt_early", 32'({hs_gnt, io_gnt}), 32'(0));
    end
    chk("gnt_owner", 32'({hs_gnt, io_gnt}),
        exp_io ? 32'(1) : 32'(2));
    chk("grant_nvram", 32'(mem_nvram), 32'(1));
    chk("grant_pause", 32'(pause_req), 32'(1));
  endtask

  task automatic owner_write(input bit io, input logic [7:0] a,
                             input logic [7:0] d);
    if (io) begin
      io_wr = 1'b1; io_addr = a; io_wdata = d;
      hs_wr = 1'($urandom_range(0, 1));
      hs_addr = 8'($urandom); hs_wdata = 8'($urandom);
    end else begin
      hs_wr = 1'b1; hs_addr = a; hs_wdata = d;
      io_wr = 1'($urandom_range(0, 1));
      io_addr = 8'($urandom); io_wdata = 8'($urandom);
    end
    tick();
    chk("wr_strobe", 32'(mem_wr), 32'(1));
    chk("wr_addr", 32'(mem_addr), 32'({8'h00, a}));
    chk("wr_data", 32'(mem_wdata), 32'(d));
    hs_wr = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic end_session(input bit io);
    if (io) io_req = 1'b0;
    else hs_req = 1'b0;
    hs_wr = 1'b0;
    io_wr = 1'b0;
    tick();
    chk("rel_gnt", 32'({hs_gnt, io_gnt}), 32'(0));
    chk("rel_pause", 32'(pause_req), 32'(0));
    chk("rel_nvram", 32'(mem_nvram), 32'(0));
    chk("rel_wr", 32'(mem_wr), 32'(0));
    last_io = io;
    cpu_paused = 1'b0;
  endtask

  initial begin
    // reset values before any clock edge
    #1;
    chk("rst_hs_gnt", 32'(hs_gnt), 32'(0));
    chk("rst_io_gnt", 32'(io_gnt), 32'(0));
    chk("rst_pause", 32'(pause_req), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_nvram", 32'(mem_nvram), 32'(0));
    chk("rst_err", 32'(timeout_err), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_pause", 32'(pause_req), 32'(0));

    // basic grant and a single write
    hs_req = 1'b1;
    handshake(pick(1, 0), 3);
    owner_write(1'b0, 8'h12, 8'hA5);
    chk("basic_addr16", 32'(mem_addr), 32'(16'h0012));
    tick();
    chk("basic_wr_drop", 32'(mem_wr), 32'(0));
    end_session(1'b0);
    tick();

    // io-only session, then both held: hs first, io second
    io_req = 1'b1;
    handshake(pick(0, 1), 1);
    end_session(1'b1);
    io_req = 1'b0;
    tick();
    hs_req = 1'b1;
    io_req = 1'b1;
    handshake(pick(1, 1), 0);
    io_wr = 1'b1; io_addr = 8'h77; io_wdata = 8'h33;
    tick();
    chk("fair_io_blocked", 32'(mem_wr), 32'(0));
    io_wr = 1'b0;
    owner_write(1'b0, 8'h21, 8'h9C);
    end_session(1'b0);
    handshake(pick(0, 1), 0);
    owner_write(1'b1, 8'hF0, 8'h0F);
    end_session(1'b1);
    io_req = 1'b0;
    tick();

    // pause glitch during settle
    hs_req = 1'b1;
    wait_pause();
    cpu_paused = 1'b1;
    tick();
    chk("glitch_a", 32'(hs_gnt), 32'(0));
    cpu_paused = 1'b0;
    tick();
    chk("glitch_b", 32'(hs_gnt), 32'(0));
    chk("glitch_pause", 32'(pause_req), 32'(1));
    cpu_paused = 1'b1;
    tick();
    chk("glitch_c", 32'(hs_gnt), 32'(0));
    tick();
    chk("glitch_d", 32'(hs_gnt), 32'(0));
    tick();
    chk("glitch_gnt", 32'(hs_gnt), 32'(1));
    end_session(1'b0);
    tick();

    // pause timeout: pause_req held exactly TIMEOUT cycles
    io_req = 1'b1;
    tick();
    chk("tmo_pause_up", 32'(pause_req), 32'(1));
    repeat (TIMEOUT - 1) tick();
    chk("tmo_before", 32'(pause_req), 32'(1));
    chk("tmo_err_before", 32'(timeout_err), 32'(0));
    tick();
    chk("tmo_pause_drop", 32'(pause_req), 32'(0));
    chk("tmo_err_set", 32'(timeout_err), 32'(1));
    last_io = 1'b1;
    io_req = 1'b0;
    tick();
    chk("tmo_err_sticky", 32'(timeout_err), 32'(1));
    io_req = 1'b1;
    handshake(pick(0, 1), 2);
    chk("tmo_err_clear", 32'(timeout_err), 32'(0));
    end_session(1'b1);
    io_req = 1'b0;
    tick();

    // ROM preempts a grant; aborted owner is not recorded
    hs_req = 1'b1;
    handshake(pick(1, 0), 0);
    rom_active = 1'b1;
    rom_wr = 1'b1; rom_addr = 16'h4000; rom_data = 8'h5A;
    tick();
    chk("rom_hs_gnt", 32'(hs_gnt), 32'(0));
    chk("rom_pause", 32'(pause_req), 32'(0));
    chk("rom_nvram", 32'(mem_nvram), 32'(0));
    chk("rom_addr", 32'(mem_addr), 32'(16'h4000));
    chk("rom_wr", 32'(mem_wr), 32'(1));
    chk("rom_data", 32'(mem_wdata), 32'(8'h5A));
    rom_addr = 16'h4001; rom_data = 8'h11;
    tick();
    chk("rom_addr2", 32'(mem_addr), 32'(16'h4001));
    rom_wr = 1'b0;
    tick();
    chk("rom_wr_off", 32'(mem_wr), 32'(0));
    rom_active = 1'b0;
    hs_req = 1'b0;
    cpu_paused = 1'b0;
    tick();
    chk("rom_exit_pause", 32'(pause_req), 32'(0));
    chk("rom_exit_wr", 32'(mem_wr), 32'(0));
    hs_req = 1'b1;
    io_req = 1'b1;
    handshake(pick(1, 1), 1);
    end_session(1'b0);
    handshake(pick(0, 1), 0);
    end_session(1'b1);
    io_req = 1'b0;
    tick();

    // asynchronous reset in the middle of a grant
    hs_req = 1'b1;
    handshake(pick(1, 0), 0);
    hs_wr = 1'b1; hs_addr = 8'h3C; hs_wdata = 8'hC3;
    tick();
    chk("pre_rst_wr", 32'(mem_wr), 32'(1));
    reset_n = 1'b0;
    #1;
    chk("arst_gnt", 32'({hs_gnt, io_gnt}), 32'(0));
    chk("arst_pause", 32'(pause_req), 32'(0));
    chk("arst_wr", 32'(mem_wr), 32'(0));
    chk("arst_nvram", 32'(mem_nvram), 32'(0));
    chk("arst_addr", 32'(mem_addr), 32'(0));
    chk("arst_wdata", 32'(mem_wdata), 32'(0));
    hs_wr = 1'b0;
    cpu_paused = 1'b0;
    tick();
    chk("arst_hold", 32'(pause_req), 32'(0));
    reset_n = 1'b1;
    last_io = 1'b1;
    io_req = 1'b1;
    tick();
    chk("rehs_gnt", 32'(hs_gnt), 32'(0));
    handshake(pick(1, 1), 1);
    end_session(1'b0);
    handshake(pick(0, 1), 0);
    owner_write(1'b1, 8'h55, 8'hAA);
    end_session(1'b1);
    io_req = 1'b0;
    tick();

    // randomized sessions against the transaction model
    for (int s = 0; s < 24; s++) begin
      bit h, i, own;
      int nw;
      {i, h} = 2'($urandom_range(1, 3));
      own = pick(h, i);
      hs_req = h;
      io_req = i;
      handshake(own, int'($urandom_range(0, 4)));
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        owner_write(own, 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          tick();
          chk("rnd_idle_wr", 32'(mem_wr), 32'(0));
        end
      end
      end_session(own);
      hs_req = 1'b0;
      io_req = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
